clk_burst_ctrl: RTL and testbench
=================================

# clk_burst_ctrl

Sequencer that emits a burst of exactly N clock pulses on a generated clock with a runtime-programmable half-period, then returns the output to idle-low and signals completion. Sits between a serial-interface master (SPI/I2C-style shifters) and its pins. It replaces a free-running fixed divider wherever the shifter needs a counted, start/stop-controlled clock. It also provides per-edge strobes so the shifter can launch and capture data in the `clk_i` domain.

## Interface

- `HALFW`, default 8: width of the half-period field, in `clk_i` cycles.
- `CNTW`, default 8: width of the pulse-count field.

Ports:
- `clk_i`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a burst; sampled only in IDLE.
- `half_period`  in  HALFW: cycles per high or low phase, latched on accepted `start`; 0 is treated as 1.
- `pulses`  in  CNTW: number of pulses in the burst, latched on accepted `start`.
- `clk_o`  out  1: generated burst clock; registered; idle level 0.
- `rise_o`  out  1: one-cycle strobe, high in the cycle `clk_o` first reads 1.
- `fall_o`  out  1: one-cycle strobe, high in the cycle `clk_o` first reads 0 after a high phase.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle completion strobe.
- `abort`  in  1: present only with `CLKBURST_ABORT_EN`.
- `aborted`  out  1: present only with `CLKBURST_ABORT_EN`.

## Operation

- States are IDLE, LOW and HIGH.
- Internal registers:
  - phase counter, HALFW bits
  - remaining-pulse counter, CNTW bits
  - latched half-period H, HALFW bits
- Reset values: state IDLE; `clk_o`, `rise_o`, `fall_o`, `busy`, `done` and `aborted` all 0; counters 0.
- **IDLE, `start` and `pulses` ≠ 0:**
  - latch H as max(`half_period`, 1) and the pulse count
  - clear the phase counter and set `busy` = 1
  - go to LOW
- **IDLE, `start` and `pulses` = 0:** no clock activity; `done` = 1 for one cycle; `busy` stays 0.
- **LOW:** the phase counter increments every cycle. When it equals H−1:
  - clear the counter
  - set `clk_o` = 1 and pulse `rise_o`
  - go to HIGH
- **HIGH:** the phase counter increments every cycle. When it equals H−1:
  - clear the counter
  - set `clk_o` = 0, pulse `fall_o` and decrement the remaining-pulse counter
  - if remaining was 1: go to IDLE, set `busy` = 0 and pulse `done`
  - otherwise: go to LOW
- `start` while `busy` = 1 is ignored.
- `half_period` and `pulses` may change freely during a burst without effect.
- Counter wrap is impossible: the counter is always cleared at H−1, and H−1 ≤ 2^HALFW − 2.

## Timing

- A `start` accepted at edge T0 gives `busy` = 1 from T0.
- For pulse k = 1..N, `clk_o` rises at edge T0 + (2k−1)·H.
- For pulse k = 1..N, `clk_o` falls at edge T0 + 2k·H.
- The last fall (T0 + 2NH) coincides with `busy`→0 and `done`→1; `done` drops one edge later.
- `busy` is high for exactly 2·N·H cycles. Output period is 2H cycles at a 50 % duty cycle.
- Back-to-back bursts: a `start` asserted during the `done` cycle is accepted, because the state is already IDLE. The next first rise is then H cycles later.
- Reset mid-burst: all outputs go to 0 immediately (asynchronously). No `done` is generated.
- `rise_o` and `fall_o` are never high in the same cycle. Neither is high in IDLE.

## Configuration

- Macro: `CLKBURST_ABORT_EN`.
- **Defined:** the `abort` and `aborted` ports exist.
  - `abort` = 1 while `busy`: the next edge forces `clk_o` = 0, state IDLE and `busy` = 0, and pulses `done`. A `fall_o` strobe is issued only if `clk_o` was 1.
  - The same edge sets `aborted` = 1. `aborted` stays set until the next accepted `start` clears it.
  - `abort` in IDLE has no effect.
  - `abort` has priority over a simultaneous phase end.
- **Undefined:** the ports are absent and a burst always runs to completion.

## Test plan

- Reset released, `start` with `half_period`=3, `pulses`=4 -> 4 pulses, each 3 cycles low and 3 high. `busy` high for 24 cycles, `done` high 1 cycle at the last fall, 4 `rise_o` and 4 `fall_o` strobes.
- `half_period`=0, `pulses`=2 -> treated as H=1: `clk_o` toggles every cycle, `busy` is high 4 cycles.
- `pulses`=0 -> `done` high the cycle after `start`. `clk_o`, `busy` and both strobes stay 0.
- Two back-to-back bursts: `start` held continuously with H=2, N=1 -> a second burst begins on the `done` cycle. `clk_o` rises 2 cycles later with no idle gap beyond the low phase.
- `rst` asserted mid-burst during a high phase -> `clk_o` 0 without waiting for an edge. No `done`; `busy` stays 0 after release until a new `start`.
- With `CLKBURST_ABORT_EN`: H=4, N=8, `abort` asserted during the 3rd high phase -> `clk_o` 0, `done` 1, `aborted` 1 on the next edge. The next `start` clears `aborted`.

Source files
------------

// File: rtl/clk_burst_ctrl.sv
// Counted burst clock generator: emits N pulses of programmable half-period H, then idles low.
// Optional CLKBURST_ABORT_EN adds an abort input and a sticky aborted flag.

module clk_burst_ctrl #(
  parameter int unsigned HALFW = 8,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             start,
`ifdef CLKBURST_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic [HALFW-1:0] half_period,
  input  logic [CNTW-1:0]  pulses,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh
  } state_e;

  state_e           state_q, state_d;
  logic [HALFW-1:0] phase_q, phase_d;
  logic [CNTW-1:0]  remain_q, remain_d;
  logic [HALFW-1:0] half_q, half_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             phase_end;

  // half_q is never 0 outside IDLE, so H-1 cannot underflow while it matters.
  assign phase_end = (phase_q == (half_q - HALFW'(1)));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    remain_d  = remain_q;
    half_d    = half_q;
    clk_d     = clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          aborted_d = 1'b0;
          if (pulses != '0) begin
            half_d   = (half_period == '0) ? HALFW'(1) : half_period;
            remain_d = pulses;
            phase_d  = '0;
            busy_d   = 1'b1;
            state_d  = StLow;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StLow: begin
        if (phase_end) begin
          phase_d = '0;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
          state_d = StHigh;
        end else begin
          phase_d = phase_q + HALFW'(1);
        end
      end
      StHigh: begin
        if (phase_end) begin
          phase_d  = '0;
          clk_d    = 1'b0;
          fall_d   = 1'b1;
          remain_d = remain_q - CNTW'(1);
          if (remain_q == CNTW'(1)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StLow;
          end
        end else begin
          phase_d = phase_q + HALFW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        clk_d   = 1'b0;
      end
    endcase

`ifdef CLKBURST_ABORT_EN
    // Abort wins over any phase end in the same cycle.
    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      phase_d   = '0;
      remain_d  = '0;
      clk_d     = 1'b0;
      rise_d    = 1'b0;
      fall_d    = clk_q;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      remain_q  <= '0;
      half_q    <= '0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      remain_q  <= remain_d;
      half_q    <= half_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign clk_o  = clk_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef CLKBURST_ABORT_EN
  assign aborted = aborted_q;
`else
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_clk_burst_ctrl.sv
// Directed self-checking bench for clk_burst_ctrl; abort checks build only with CLKBURST_ABORT_EN.

module tb_clk_burst_ctrl;

  logic       clk_i = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic [7:0] half_period = '0;
  logic [7:0] pulses = '0;
  logic       clk_o, rise_o, fall_o, busy, done;
`ifdef CLKBURST_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif

  int total = 0;
  int bad   = 0;

  clk_burst_ctrl #(
    .HALFW(8),
    .CNTW (8)
  ) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .start      (start),
`ifdef CLKBURST_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .half_period(half_period),
    .pulses     (pulses),
    .clk_o      (clk_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Start a burst and watch it cycle by cycle; eh is the effective half-period.
  // Sample index c counts negedges after the accepting edge T0.
  task automatic run_burst(input string name, input logic [7:0] h, input logic [7:0] n,
                           input int eh);
    int len, nb, nr, nf, nd, done_at, first_rise, clk_errs, both;
    logic exp_clk;
    len = 2 * int'(n) * eh;
    nb = 0; nr = 0; nf = 0; nd = 0; done_at = -1; first_rise = -1; clk_errs = 0; both = 0;
    @(negedge clk_i);
    start = 1'b1; half_period = h; pulses = n;
    @(negedge clk_i);
    // Inputs change mid-burst; must have no effect.
    start = 1'b0; half_period = 8'hff; pulses = 8'hff;
    for (int c = 0; c <= len + 1; c++) begin
      exp_clk = (c < len) && (((c / eh) % 2) == 1);
      if (clk_o !== exp_clk) clk_errs++;
      nb += int'(busy);
      nr += int'(rise_o);
      nf += int'(fall_o);
      if (done) begin nd++; done_at = c; end
      if (rise_o && first_rise < 0) first_rise = c;
      if (rise_o && fall_o) both++;
      @(negedge clk_i);
    end
    check_eq({name, " clk_pattern_errs"}, clk_errs, 0);
    check_eq({name, " busy_cycles"}, nb, len);
    check_eq({name, " rise_count"}, nr, int'(n));
    check_eq({name, " fall_count"}, nf, int'(n));
    check_eq({name, " done_count"}, nd, 1);
    check_eq({name, " done_cycle"}, done_at, len);
    check_eq({name, " first_rise"}, first_rise, (n == 0) ? -1 : eh);
    check_eq({name, " strobe_overlap"}, both, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, nc;
    rst = 1'b1;
    @(negedge clk_i);
    check_eq("reset clk_o", clk_o, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);
    check_eq("reset strobes", {rise_o, fall_o}, 0);
`ifdef CLKBURST_ABORT_EN
    check_eq("reset aborted", aborted, 0);
`endif
    @(negedge clk_i);
    rst = 1'b0;

    run_burst("h3n4", 8'd3, 8'd4, 3);
    run_burst("h0n2", 8'd0, 8'd2, 1);
    run_burst("n0", 8'd5, 8'd0, 1);
    run_burst("h1n3", 8'd1, 8'd3, 1);

    // Back-to-back: start held with H=2, N=1.
    @(negedge clk_i);
    start = 1'b1; half_period = 8'd2; pulses = 8'd1;
    @(negedge clk_i);                 // c=0
    check_eq("b2b busy c0", busy, 1);
    repeat (2) @(negedge clk_i);      // c=2
    check_eq("b2b rise c2", {clk_o, rise_o}, 2'b11);
    repeat (2) @(negedge clk_i);      // c=4
    check_eq("b2b done c4", {done, busy, fall_o, clk_o}, 4'b1010);
    @(negedge clk_i);                 // c=5
    check_eq("b2b rebusy c5", {busy, clk_o, done}, 3'b100);
    start = 1'b0;
    @(negedge clk_i);                 // c=6
    check_eq("b2b low c6", clk_o, 0);
    @(negedge clk_i);                 // c=7
    check_eq("b2b rise c7", {clk_o, rise_o}, 2'b11);
    repeat (2) @(negedge clk_i);      // c=9
    check_eq("b2b done c9", {done, busy}, 2'b10);
    @(negedge clk_i);
    check_eq("b2b idle", {done, busy, clk_o}, 3'b000);

    // Reset during a high phase (H=3: high for c=3..5).
    start = 1'b1; half_period = 8'd3; pulses = 8'd4;
    @(negedge clk_i);
    start = 1'b0;
    repeat (4) @(negedge clk_i);      // c=4
    check_eq("rst pre clk_o", clk_o, 1);
    rst = 1'b1;
    #1;
    check_eq("rst async clk_o", clk_o, 0);
    check_eq("rst async busy", busy, 0);
    repeat (2) @(negedge clk_i);
    rst = 1'b0;
    nb = 0; nd = 0; nc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      nb += int'(busy); nd += int'(done); nc += int'(clk_o);
    end
    check_eq("rst post busy", nb, 0);
    check_eq("rst post done", nd, 0);
    check_eq("rst post clk", nc, 0);

`ifdef CLKBURST_ABORT_EN
    // H=4, N=8; third high phase spans c=20..23.
    @(negedge clk_i);
    start = 1'b1; half_period = 8'd4; pulses = 8'd8;
    @(negedge clk_i);
    start = 1'b0;
    repeat (21) @(negedge clk_i);     // c=21
    check_eq("abort pre clk", {clk_o, busy}, 2'b11);
    abort = 1'b1;
    @(negedge clk_i);                 // c=22
    abort = 1'b0;
    check_eq("abort edge", {clk_o, done, aborted, busy, fall_o}, 5'b01101);
    @(negedge clk_i);
    check_eq("abort hold", {done, aborted, busy}, 3'b010);
    abort = 1'b1;
    @(negedge clk_i);
    abort = 1'b0;
    check_eq("abort idle", {done, busy}, 2'b00);
    start = 1'b1; half_period = 8'd1; pulses = 8'd1;
    @(negedge clk_i);
    start = 1'b0;
    check_eq("abort cleared", {aborted, busy}, 2'b01);
    repeat (3) @(negedge clk_i);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
